// File: rtl/mem_load_wb_stage.sv
// MEM-stage load path: issues word-aligned reads to a variable-latency data memory,
// extracts/extends the loaded value and registers the MEM/WB record. Optional macro: LOAD_MISALIGN_TRAP_EN.
module mem_load_wb_stage #(
  parameter int MAX_WAIT   = 255,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        flush,
  input  logic [31:0] ex_mem_alu_out,
  input  logic        ex_mem_ctrl_mem_to_reg,
  input  logic [2:0]  ex_mem_ctrl_load_type,
  input  logic        ex_mem_ctrl_reg_write,
  input  logic [4:0]  ex_mem_rd,
  output logic        dmem_rd_req,
  output logic [31:0] dmem_rd_addr,
  input  logic        dmem_rd_valid,
  input  logic [31:0] dmem_rd_data,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        rd_req_nx, wb_valid_nx, wb_we_nx, bus_err_nx, addr_err_nx;
  logic [4:0]  wb_rd_nx;
  logic [31:0] wb_data_nx, rd_addr_nx;
  logic        accept, misalign, latch_en;

  logic [1:0]  ld_off_p0;
  logic [2:0]  ld_type_p0;
  logic [4:0]  ld_rd_p0;
  logic        ld_we_p0;

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  typ);
    logic [1:0]  k;
    logic        hs;
    logic [7:0]  b;
    logic [15:0] h;
    k  = BIG_ENDIAN ? ~off : off;
    hs = BIG_ENDIAN ? ~off[1] : off[1];
    b  = word[{k, 3'b000} +: 8];
    h  = word[{hs, 4'b0000} +: 16];
    case (typ)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {24'b0, b};
      3'd2:    return {{16{h[15]}}, h};
      3'd3:    return {16'b0, h};
      default: return word;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && !flush;

`ifdef LOAD_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (ex_mem_ctrl_load_type == 3'd2 || ex_mem_ctrl_load_type == 3'd3)
      misalign = ex_mem_alu_out[0];
    else if (ex_mem_ctrl_load_type >= 3'd4)
      misalign = |ex_mem_alu_out[1:0];
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    rd_req_nx   = 1'b0;
    rd_addr_nx  = dmem_rd_addr;
    wb_valid_nx = 1'b0;
    wb_we_nx    = 1'b0;
    wb_rd_nx    = wb_rd;
    wb_data_nx  = wb_data;
    bus_err_nx  = 1'b0;
    addr_err_nx = 1'b0;
    latch_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!ex_mem_ctrl_mem_to_reg || misalign) begin
            // Non-loads and trapped loads both retire on the next edge without memory.
            wb_valid_nx = 1'b1;
            wb_we_nx    = !ex_mem_ctrl_mem_to_reg && ex_mem_ctrl_reg_write && (ex_mem_rd != 5'd0);
            wb_rd_nx    = ex_mem_rd;
            wb_data_nx  = ex_mem_alu_out;
            addr_err_nx = ex_mem_ctrl_mem_to_reg;
          end else begin
            state_nx   = WAIT;
            cnt_nx     = 8'd0;
            rd_req_nx  = 1'b1;
            rd_addr_nx = {ex_mem_alu_out[31:2], 2'b00};
            latch_en   = 1'b1;
          end
        end
      end
      WAIT, DRAIN: begin
        if (dmem_rd_valid) begin
          state_nx = IDLE;
          if (state == WAIT && !flush) begin
            wb_valid_nx = 1'b1;
            wb_we_nx    = ld_we_p0;
            wb_rd_nx    = ld_rd_p0;
            wb_data_nx  = extract_load(dmem_rd_data, ld_off_p0, ld_type_p0);
          end
        end else if (cnt == WD_LAST) begin
          state_nx = IDLE;
          if (state == WAIT && !flush) begin
            wb_valid_nx = 1'b1;
            wb_rd_nx    = ld_rd_p0;
            bus_err_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
          if (flush) state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      dmem_rd_req  <= 1'b0;
      dmem_rd_addr <= 32'd0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      bus_err      <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      dmem_rd_req  <= rd_req_nx;
      dmem_rd_addr <= rd_addr_nx;
      wb_valid     <= wb_valid_nx;
      wb_reg_write <= wb_we_nx;
      wb_rd        <= wb_rd_nx;
      wb_data      <= wb_data_nx;
      bus_err      <= bus_err_nx;
      addr_err     <= addr_err_nx;
    end
  end

  // Load issue boundary: record captured for use when the response arrives.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      ld_off_p0  <= ex_mem_alu_out[1:0];
      ld_type_p0 <= ex_mem_ctrl_load_type;
      ld_rd_p0   <= ex_mem_rd;
      ld_we_p0   <= ex_mem_ctrl_reg_write && (ex_mem_rd != 5'd0);
    end
  end

endmodule
